// File: rtl/jtkicker_objscan.sv
// jtkicker_objscan: per-line object table scanner feeding hit sprites to a draw engine through a small FIFO
module jtkicker_objscan #(
  parameter int MAXOBJ   = 24,
  parameter int AW       = 7,
  parameter int OBJH     = 16,
  parameter int REV_SCAN = 0,
  parameter int YINV     = 1,
  parameter int YADJ     = 0,
  parameter int MAXLINE  = 24,
  parameter int FIFOD    = 4
)(
  input  logic                      rst,
  input  logic                      clk,
  input  logic                      cen_i,
  input  logic                      hinit_i,
  input  logic [7:0]                vrender_i,
  output logic [AW-1:0]             scan_addr_o,
  input  logic [7:0]                scan_dout_i,
  output logic                      obj_valid_o,
  input  logic                      obj_ready_i,
  output logic [7:0]                obj_code_o,
  output logic [7:0]                obj_xpos_o,
  output logic [7:0]                obj_attr_o,
  output logic [$clog2(OBJH)-1:0]   obj_ysub_o,
  output logic                      scan_done_o,
  output logic                      overflow_o
);
  localparam int IW = AW - 2;
  localparam int YW = $clog2(OBJH);
  localparam int FW = $clog2(FIFOD);
  localparam int CW = FW + 1;
  localparam int HW = $clog2(MAXLINE + 1);
  localparam int EW = 24 + YW;
  localparam logic [IW-1:0] FIRST = IW'(REV_SCAN != 0 ? MAXOBJ - 1 : 0);
  localparam logic [IW-1:0] LAST  = IW'(REV_SCAN != 0 ? 0 : MAXOBJ - 1);

  typedef enum logic [2:0] {IDLE, RDY, RDCODE, RDX, RDATTR} st_t;

  st_t           st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    byte_q, byte_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [YW-1:0] ysub_q, ysub_d;
  logic [7:0]    code_q, code_d, x_q, x_d;
  logic          inzone_q, inzone_d, done_q, done_d, ovf_q, ovf_d, hin_q;
  logic [EW-1:0] mem_q [FIFOD];
  logic [FW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    y, ydiff;
  logic          hin, full, pop, want, stall, push, flush;

  assign obj_valid_o = cnt_q != '0;
  assign {obj_code_o, obj_xpos_o, obj_attr_o, obj_ysub_o} = mem_q[rd_q];
  assign scan_done_o = done_q;
  assign overflow_o  = ovf_q;

  // scan_addr_o presents the byte the next state consumes, so the one-cycle RAM latency lines up
  always_comb begin
    hin      = hin_q | hinit_i;
    y        = (YINV != 0 ? ~scan_dout_i : scan_dout_i) + 8'(YADJ);
    ydiff    = vrender_i - y;
    full     = cnt_q == CW'(FIFOD);
    pop      = cen_i & obj_valid_o & obj_ready_i;
    want     = st_q == RDATTR && inzone_q && hits_q < HW'(MAXLINE);
    stall    = want & full & ~pop;
    st_d     = st_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    hits_d   = hits_q;
    ysub_d   = ysub_q;
    code_d   = code_q;
    x_d      = x_q;
    inzone_d = inzone_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    flush    = 1'b0;
    if (hin) begin
      st_d   = RDY;
      idx_d  = FIRST;
      byte_d = 2'd0;
      hits_d = '0;
      done_d = 1'b0;
      ovf_d  = st_q != IDLE;
      flush  = 1'b1;
    end else begin
      unique case (st_q)
        RDY: begin
          inzone_d = ydiff[7:YW] == '0;
          ysub_d   = ydiff[YW-1:0];
          byte_d   = 2'd1;
          st_d     = RDCODE;
        end
        RDCODE: begin
          code_d = scan_dout_i;
          byte_d = 2'd2;
          st_d   = RDX;
        end
        RDX: begin
          x_d    = scan_dout_i;
          byte_d = 2'd3;
          st_d   = RDATTR;
        end
        RDATTR: if (!stall) begin
          push   = want;
          hits_d = hits_q + HW'(want);
          ovf_d  = ovf_q | (inzone_q & ~want);
          byte_d = 2'd0;
          done_d = idx_q == LAST;
          st_d   = idx_q == LAST ? IDLE : RDY;
          idx_d  = idx_q == LAST ? idx_q : REV_SCAN != 0 ? idx_q - IW'(1) : idx_q + IW'(1);
        end
        default: ;
      endcase
    end
    scan_addr_o = {idx_d, byte_d};
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      idx_q    <= '0;
      byte_q   <= '0;
      hits_q   <= '0;
      ysub_q   <= '0;
      code_q   <= '0;
      x_q      <= '0;
      inzone_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hin_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFOD; i++) mem_q[i] <= '0;
    end else begin
      hin_q <= hin & ~cen_i;
      if (cen_i) begin
        st_q     <= st_d;
        idx_q    <= idx_d;
        byte_q   <= byte_d;
        hits_q   <= hits_d;
        ysub_q   <= ysub_d;
        code_q   <= code_d;
        x_q      <= x_d;
        inzone_q <= inzone_d;
        done_q   <= done_d;
        ovf_q    <= ovf_d;
        if (flush) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          if (push) begin
            mem_q[wr_q] <= {code_q, x_q, scan_dout_i, ysub_q};
            wr_q        <= wr_q + FW'(1);
          end
          if (pop) rd_q <= rd_q + FW'(1);
          cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
      end
    end
  end
endmodule

// File: tb/tb_jtkicker_objscan.sv
// tb_jtkicker_objscan: default instance plus a reverse-scan, 8-per-line instance sharing one object RAM
module tb_jtkicker_objscan;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b1, hinit = 1'b0, ready = 1'b1;
  logic [7:0] vrender = '0;
  logic [6:0] addr0, addr1;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic valid0, valid1, done0, done1, ovf0, ovf1;
  logic [7:0] code0, code1, x0, x1, attr0, attr1;
  logic [3:0] ysub0, ysub1;
  logic [7:0] ram [128];
  logic [27:0] q0 [$];
  logic [27:0] q1 [$];
  int checks = 0, failures = 0, pops0 = 0, pops1 = 0;
  bit half = 1'b0, eo0, eo1;

  typedef struct { logic [7:0] y; logic [7:0] v; bit hit; logic [3:0] ysub; } vec_t;
  vec_t tbl [8];

  jtkicker_objscan u_dut (
    .rst(rst), .clk(clk), .cen_i(cen), .hinit_i(hinit), .vrender_i(vrender),
    .scan_addr_o(addr0), .scan_dout_i(dout0), .obj_valid_o(valid0), .obj_ready_i(ready),
    .obj_code_o(code0), .obj_xpos_o(x0), .obj_attr_o(attr0), .obj_ysub_o(ysub0),
    .scan_done_o(done0), .overflow_o(ovf0));

  jtkicker_objscan #(.REV_SCAN(1), .MAXLINE(8)) u_alt (
    .rst(rst), .clk(clk), .cen_i(cen), .hinit_i(hinit), .vrender_i(vrender),
    .scan_addr_o(addr1), .scan_dout_i(dout1), .obj_valid_o(valid1), .obj_ready_i(ready),
    .obj_code_o(code1), .obj_xpos_o(x1), .obj_attr_o(attr1), .obj_ysub_o(ysub1),
    .scan_done_o(done1), .overflow_o(ovf1));

  always #5 clk = ~clk;

  always @(posedge clk) if (cen) begin
    dout0 <= ram[addr0];
    dout1 <= ram[addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard side: every accepted head is compared with the oldest expected entry
  always @(negedge clk) if (!rst && cen && ready) begin
    if (valid0) begin
      pops0++;
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL pop0 unexpected head=%0h", {code0, x0, attr0, ysub0});
      end else begin
        if ({code0, x0, attr0, ysub0} !== q0[0]) begin
          failures++;
          $display("FAIL pop0 actual=%0h required=%0h", {code0, x0, attr0, ysub0}, q0[0]);
        end
        void'(q0.pop_front());
      end
    end
    if (valid1) begin
      pops1++;
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL pop1 unexpected head=%0h", {code1, x1, attr1, ysub1});
      end else begin
        if ({code1, x1, attr1, ysub1} !== q1[0]) begin
          failures++;
          $display("FAIL pop1 actual=%0h required=%0h", {code1, x1, attr1, ysub1}, q1[0]);
        end
        void'(q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cen = half ? ~cen : 1'b1;
  endtask

  task automatic clear_ram(input logic [7:0] v);
    logic [7:0] far;
    far = v + 8'd128;
    for (int i = 0; i < 32; i++) begin
      ram[4*i]   = ~far;
      ram[4*i+1] = 8'h10 + 8'(i);
      ram[4*i+2] = 8'h40 + 8'(i);
      ram[4*i+3] = 8'h80 + 8'(i);
    end
  endtask

  function automatic logic [27:0] entry(input int i, input logic [3:0] ys);
    return {ram[4*i+1], ram[4*i+2], ram[4*i+3], ys};
  endfunction

  task automatic model(input logic [7:0] v);
    int h, i;
    bit o;
    logic [7:0] y, d;
    for (int r = 0; r < 2; r++) begin
      h = 0;
      o = 1'b0;
      for (int k = 0; k < 24; k++) begin
        i = r != 0 ? 23 - k : k;
        y = ~ram[4*i];
        d = v - y;
        if (d < 8'd16) begin
          if (h < (r != 0 ? 8 : 24)) begin
            h++;
            if (r != 0) q1.push_back(entry(i, d[3:0]));
            else q0.push_back(entry(i, d[3:0]));
          end else o = 1'b1;
        end
      end
      if (r != 0) eo1 = o;
      else eo0 = o;
    end
  endtask

  task automatic start_line(input bit chk_first);
    bit c;
    tick();
    hinit = 1'b1;
    if (chk_first) begin
      #1;
      chk("first_addr_fwd", addr0, 7'd0);
      chk("first_addr_rev", addr1, {5'd23, 2'd0});
    end
    do begin
      c = cen;
      tick();
    end while (!c);
    hinit = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n0);
    int n;
    n = 0;
    n0 = 0;
    do begin
      tick();
      n++;
      if (done0 && n0 == 0) n0 = n;
    end while (!(done0 && done1) && n < budget);
    if (!(done0 && done1)) begin
      checks++;
      failures++;
      $display("FAIL scan_done timeout done0=%0b done1=%0b", done0, done1);
    end
  endtask

  task automatic drain(input string name);
    repeat (12) tick();
    chk({name, "_drain0"}, 32'(q0.size()), 0);
    chk({name, "_drain1"}, 32'(q1.size()), 0);
    chk({name, "_valid"}, {valid0, valid1}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    logic [6:0] a0, a1;
    tbl[0] = '{8'd40,  8'd45,  1'b1, 4'd5};
    tbl[1] = '{8'd250, 8'd4,   1'b1, 4'd10};
    tbl[2] = '{8'd250, 8'd10,  1'b0, 4'd0};
    tbl[3] = '{8'd45,  8'd45,  1'b1, 4'd0};
    tbl[4] = '{8'd30,  8'd45,  1'b1, 4'd15};
    tbl[5] = '{8'd29,  8'd45,  1'b0, 4'd0};
    tbl[6] = '{8'd46,  8'd45,  1'b0, 4'd0};
    tbl[7] = '{8'd240, 8'd255, 1'b1, 4'd15};
    clear_ram(8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {valid0, valid1}, 2'b00);
    chk("rst_head0", {code0, x0, attr0, ysub0}, 0);
    chk("rst_flags", {done0, ovf0, done1, ovf1}, 4'b0000);
    chk("rst_addr", {addr0, addr1}, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int j = 0; j < 8; j++) begin
      t = (j * 3) % 24;
      vrender = tbl[j].v;
      clear_ram(tbl[j].v);
      ram[4*t] = ~tbl[j].y;
      if (tbl[j].hit) begin
        q0.push_back(entry(t, tbl[j].ysub));
        q1.push_back(entry(t, tbl[j].ysub));
      end
      half = j == 7;
      start_line(1'b0);
      wait_done(400, n);
      if (!half) chk("done_latency", n, 96);
      half = 1'b0;
      drain("vec");
      chk("vec_ovf", {ovf0, ovf1}, 2'b00);
    end

    vrender = 8'd45;
    clear_ram(8'd45);
    for (int k = 0; k < 24; k++) ram[4*k] = ~(8'd45 - 8'(k % 16));
    model(8'd45);
    pops0 = 0;
    pops1 = 0;
    start_line(1'b1);
    wait_done(200, n);
    drain("limit");
    chk("limit_pops_fwd", pops0, 24);
    chk("limit_pops_rev", pops1, 8);
    chk("limit_ovf_fwd", ovf0, eo0);
    chk("limit_ovf_rev", ovf1, eo1);

    clear_ram(8'd45);
    for (int k = 0; k < 6; k++) ram[4*k] = ~(8'd45 - 8'(k));
    model(8'd45);
    ready = 1'b0;
    start_line(1'b0);
    repeat (120) tick();
    chk("stall_valid", {valid0, valid1}, 2'b11);
    chk("stall_done", {done0, done1}, 2'b00);
    a0 = addr0;
    a1 = addr1;
    repeat (10) tick();
    chk("stall_addr0", addr0, a0);
    chk("stall_addr1", addr1, a1);
    chk("stall_queued", {32'(q0.size()), 32'(q1.size())} == {32'd6, 32'd6}, 1);
    ready = 1'b1;
    wait_done(200, n);
    drain("stall");

    clear_ram(8'd45);
    ram[32] = ~8'd45;
    ram[36] = ~8'd42;
    model(8'd45);
    ready = 1'b0;
    start_line(1'b0);
    n = 0;
    while (addr0[6:2] != 5'd10 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_reach", addr0[6:2], 5'd10);
    chk("abort_pre_valid", valid0, 1'b1);
    hinit = 1'b1;
    tick();
    hinit = 1'b0;
    chk("abort_valid", {valid0, valid1}, 2'b00);
    chk("abort_ovf", {ovf0, ovf1}, 2'b11);
    chk("abort_done", {done0, done1}, 2'b00);
    chk("abort_idx_fwd", addr0[6:2], 5'd0);
    chk("abort_idx_rev", addr1[6:2], 5'd23);
    q0.delete();
    q1.delete();
    model(8'd45);
    ready = 1'b1;
    wait_done(200, n);
    drain("abort");

    clear_ram(8'd45);
    for (int k = 0; k < 6; k++) ram[4*k] = ~(8'd45 - 8'(k));
    ready = 1'b0;
    start_line(1'b0);
    repeat (40) tick();
    chk("mid_pre_valid", valid0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {valid0, valid1}, 2'b00);
    chk("mid_rst_head0", {code0, x0, attr0, ysub0}, 0);
    chk("mid_rst_head1", {code1, x1, attr1, ysub1}, 0);
    chk("mid_rst_flags", {done0, ovf0, done1, ovf1}, 4'b0000);
    chk("mid_rst_addr", {addr0, addr1}, 0);
    q0.delete();
    q1.delete();
    repeat (2) tick();
    rst = 1'b0;
    ready = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
